// File: rtl/alu_pipe.sv
// Pipelined integer ALU with valid/ready on both sides, status flags and optional
// signed saturation. The result is computed before stage 0; later stages only delay it.
module alu_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter bit SAT    = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       op_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int SHW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int M   = WIDTH - 1;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_SRL = 3'd7;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res_d;
    logic [3:0]       flg_d;
    logic             carry;
    logic             ovf;
    logic [SHW-1:0]   sh;

    assign sh = b_in[SHW-1:0];

    always_comb begin
        sum   = '0;
        res_d = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (op_in)
            OP_NOP: res_d = '0;
            OP_ADD: begin
                sum   = {1'b0, a_in} + {1'b0, b_in};
                res_d = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (a_in[M] == b_in[M]) && (sum[M] != a_in[M]);
            end
            OP_SUB: begin
                sum   = {1'b0, a_in} + {1'b0, ~b_in} + (WIDTH+1)'(1);
                res_d = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (a_in[M] != b_in[M]) && (sum[M] != a_in[M]);
            end
            OP_AND: res_d = a_in & b_in;
            OP_OR:  res_d = a_in | b_in;
            OP_XOR: res_d = a_in ^ b_in;
            OP_SLL: res_d = a_in << sh;
            OP_SRL: res_d = a_in >> sh;
            default: res_d = '0;
        endcase
        // On overflow the true result has the sign of operand A.
        if (SAT && ovf) begin
            res_d = a_in[M] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
        flg_d = {res_d[M], (res_d == '0), carry, ovf};
    end

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] room;
    logic              room_acc;
    logic [WIDTH-1:0]  res_q   [STAGES];
    logic [3:0]        flg_q   [STAGES];
    logic [STAGES-1:0] src_v;
    logic [WIDTH-1:0]  src_res [STAGES];
    logic [3:0]        src_flg [STAGES];

    // A stage can take new data if it or any stage after it is empty, or the consumer is taking.
    always_comb begin
        room_acc = out_ready;
        room     = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            room_acc = room_acc | ~v[k];
            room[k]  = room_acc;
        end
    end

    always_comb begin
        src_v      = '0;
        src_v[0]   = in_valid;
        src_res[0] = res_d;
        src_flg[0] = flg_d;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k]   = v[k-1];
            src_res[k] = res_q[k-1];
            src_flg[k] = flg_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int k = 0; k < STAGES; k++) begin
                res_q[k] <= '0;
                flg_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (room[k]) begin
                    v[k] <= src_v[k];
                    if (src_v[k]) begin
                        res_q[k] <= src_res[k];
                        flg_q[k] <= src_flg[k];
                    end
                end
            end
        end
    end

    assign in_ready  = room[0];
    assign out       = res_q[STAGES-1];
    assign flags     = flg_q[STAGES-1];
    assign out_valid = v[STAGES-1];
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: a wrap instance and a saturating instance share stimulus; a
// scoreboard checks every retired result against an arithmetic model of the op set.
module tb_alu_pipe;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   op_in = '0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic         in_ready0, in_ready1;
    logic [W-1:0] out0, out1;
    logic [3:0]   flags0, flags1;
    logic         out_valid0, out_valid1;

    int checks = 0;
    int errors = 0;
    int retire_cnt = 0;
    bit drop_seen = 1'b0;
    logic [11:0] exp0_q[$];
    logic [11:0] exp1_q[$];

    alu_pipe #(.WIDTH(W), .STAGES(2), .SAT(1'b0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .op_in(op_in), .a_in(a_in), .b_in(b_in),
        .in_valid(in_valid), .in_ready(in_ready0), .out(out0), .flags(flags0),
        .out_valid(out_valid0), .out_ready(out_ready)
    );

    alu_pipe #(.WIDTH(W), .STAGES(2), .SAT(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .op_in(op_in), .a_in(a_in), .b_in(b_in),
        .in_valid(in_valid), .in_ready(in_ready1), .out(out1), .flags(flags1),
        .out_valid(out_valid1), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Returns {N,Z,C,V,result} from plain integer arithmetic.
    function automatic logic [11:0] model(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input bit sat);
        int ua = a;
        int ub = b;
        int sa = $signed(a);
        int sb = $signed(b);
        int t = 0;
        int sh = b % 8;
        logic [7:0] r = 8'h00;
        bit c = 1'b0;
        bit v = 1'b0;
        case (op)
            3'd1: begin
                t = sa + sb;
                r = 8'((ua + ub) % 256);
                c = (ua + ub) > 255;
                v = (t > 127) || (t < -128);
            end
            3'd2: begin
                t = sa - sb;
                r = 8'((ua + 256 - ub) % 256);
                c = ua >= ub;
                v = (t > 127) || (t < -128);
            end
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: r = 8'((ua * (1 << sh)) % 256);
            3'd7: r = 8'(ua / (1 << sh));
            default: r = 8'h00;
        endcase
        if (sat && v) r = (t > 127) ? 8'h7F : 8'h80;
        return {r[7], (r == 8'h00), c, v, r};
    endfunction

    // Mid-cycle scoreboard: handshakes seen here complete at the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp0_q.delete();
            exp1_q.delete();
        end else begin
            if (in_valid && !in_ready0) drop_seen = 1'b1;
            if (out_valid0) begin
                if (exp0_q.size() == 0) chk("wrap_unexpected_valid", 1, 0);
                else chk("wrap_result", {flags0, out0}, exp0_q[0]);
            end
            if (out_valid1) begin
                if (exp1_q.size() == 0) chk("sat_unexpected_valid", 1, 0);
                else chk("sat_result", {flags1, out1}, exp1_q[0]);
            end
            if (out_valid0 && out_ready && exp0_q.size() > 0) begin
                void'(exp0_q.pop_front());
                retire_cnt++;
            end
            if (out_valid1 && out_ready && exp1_q.size() > 0) void'(exp1_q.pop_front());
            if (in_valid && in_ready0) begin
                exp0_q.push_back(model(op_in, a_in, b_in, 1'b0));
                exp1_q.push_back(model(op_in, a_in, b_in, 1'b1));
            end
        end
    end

    // Called and returns at 2 time units after a rising edge.
    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        bit ok;
        int n;
        op_in = op;
        a_in = a;
        b_in = b;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            ok = in_ready0;
            @(posedge clk);
            #2;
            n++;
        end while (!ok && n < 50);
        if (!ok) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic check_one(input string name, input logic [2:0] op, input logic [7:0] a,
                             input logic [7:0] b, input logic [11:0] e_wrap,
                             input logic [11:0] e_sat);
        int n;
        out_ready = 1'b1;
        send(op, a, b);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid0 && n < 20);
        chk({name, "_latency"}, n, 2);
        chk({name, "_wrap"}, {flags0, out0}, e_wrap);
        chk({name, "_sat"}, {flags1, out1}, e_sat);
        @(posedge clk);
        #2;
    endtask

    logic [2:0] s_op [10] = '{3'd3, 3'd4, 3'd5, 3'd1, 3'd2, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
    logic [7:0] s_a  [10] = '{8'hF0, 8'h0F, 8'hAA, 8'h80, 8'h7F, 8'h03, 8'hFF, 8'h12, 8'hC0, 8'h01};
    logic [7:0] s_b  [10] = '{8'h3C, 8'h30, 8'hFF, 8'h80, 8'hFF, 8'h0D, 8'h14, 8'h34, 8'hC0, 8'h7F};
    logic [15:0] rdy_pat = 16'b1011_0010_1101_0011;

    initial begin
        int base;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_out_valid", out_valid0, 0);
        chk("reset_out", out0, 0);
        chk("reset_flags", flags0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", in_ready0, 1);
        @(posedge clk);
        #2;

        // {N,Z,C,V,result}
        check_one("add_7f_01", 3'd1, 8'h7F, 8'h01, 12'h980, 12'h17F);
        check_one("sub_05_05", 3'd2, 8'h05, 8'h05, 12'h600, 12'h600);
        check_one("sub_00_01", 3'd2, 8'h00, 8'h01, 12'h8FF, 12'h8FF);
        check_one("sll_81_09", 3'd6, 8'h81, 8'h09, 12'h002, 12'h002);
        check_one("srl_80_07", 3'd7, 8'h80, 8'h07, 12'h001, 12'h001);
        check_one("sub_80_01", 3'd2, 8'h80, 8'h01, 12'h37F, 12'hB80);
        check_one("nop", 3'd0, 8'h05, 8'h09, 12'h400, 12'h400);

        // Six back-to-back ops with the consumer stalled in cycles 3-6.
        drop_seen = 1'b0;
        base = retire_cnt;
        fork
            begin
                for (int i = 0; i < 6; i++) send(3'(i + 1), 8'(8'h10 * i + 3), 8'(8'h21 + i));
            end
            begin
                for (int c = 1; c <= 10; c++) begin
                    out_ready = !(c >= 3 && c <= 6);
                    @(posedge clk);
                    #2;
                end
                out_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #2;
        chk("bp_in_ready_drop", drop_seen, 1);
        chk("bp_retired", retire_cnt - base, 6);

        // Mixed op stream under an irregular consumer.
        base = retire_cnt;
        fork
            begin
                for (int i = 0; i < 10; i++) send(s_op[i], s_a[i], s_b[i]);
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    out_ready = rdy_pat[c % 16];
                    @(posedge clk);
                    #2;
                end
                out_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #2;
        chk("stream_retired", retire_cnt - base, 10);

        // Reset with two ops held in the pipe: neither may ever appear.
        out_ready = 1'b0;
        send(3'd1, 8'h11, 8'h22);
        send(3'd5, 8'h0F, 8'hF0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", out_valid0, 0);
        chk("midreset_out", out0, 0);
        chk("midreset_flags", flags0, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        base = retire_cnt;
        check_one("post_reset_add", 3'd1, 8'h40, 8'h40, 12'h980, 12'h17F);
        repeat (4) @(posedge clk);
        #2;
        chk("post_reset_retired", retire_cnt - base, 1);

        chk("wrap_queue_empty", exp0_q.size(), 0);
        chk("sat_queue_empty", exp1_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
